// File: rtl/knot_lock_pkg.sv
// Shared types and constants for the time-multiplexed key interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package knot_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_RUN
    } knot_state_e;

    localparam int KNOT_KEY_W   = 7;
    localparam int KNOT_NKEY    = 2;
    localparam int KNOT_WIN_LEN = 7;

    localparam logic [6:0] KNOT2_KEY0 = 7'd66;
    localparam logic [6:0] KNOT2_KEY1 = 7'd11;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knot_window_counter.sv
// Phase/window counter: phase 0..WIN_LEN-1, window advances when phase wraps.
// Latency: win_idx and win_start registered; win_idx_nxt is the value after the next edge.
// Backpressure: none; en advances, clr zeroes synchronously and wins over en.
module knot_window_counter
    import knot_lock_pkg::*;
#(
    parameter int NKEY    = KNOT_NKEY,
    parameter int WIN_LEN = KNOT_WIN_LEN,
    localparam int IW     = idx_w(NKEY),
    localparam int PW     = idx_w(WIN_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [IW-1:0] win_idx,
    output logic [IW-1:0] win_idx_nxt,
    output logic          win_start
);

    localparam logic [PW-1:0] PH_LAST  = PW'(WIN_LEN - 1);
    localparam logic [IW-1:0] WIN_LAST = IW'(NKEY - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [IW-1:0] win_q, win_d;
    logic          win_start_q, win_start_d;

    always_comb begin
        phase_d = phase_q;
        win_d   = win_q;
        if (clr) begin
            phase_d = '0;
            win_d   = '0;
        end else if (en) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                win_d   = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        // Entering RUN holds the already-cleared phase 0, so the first cycle pulses too.
        win_start_d = !clr && (phase_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            win_q       <= '0;
            win_start_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            win_q       <= win_d;
            win_start_q <= win_start_d;
        end
    end

    assign win_idx     = win_q;
    assign win_idx_nxt = win_d;
    assign win_start   = win_start_q;

endmodule

// File: rtl/knot_key_sequencer.sv
// Stores NKEY key words and drives them onto the keyinput bus one window at a time.
// Latency: outputs registered; first RUN cycle already shows key[0] with win_start.
// Backpressure: load_ready high only in IDLE/LOAD; words offered elsewhere are ignored.
module knot_key_sequencer
    import knot_lock_pkg::*;
#(
    parameter int KEY_W   = KNOT_KEY_W,
    parameter int NKEY    = KNOT_NKEY,
    parameter int WIN_LEN = KNOT_WIN_LEN,
    localparam int IW     = idx_w(NKEY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [KEY_W-1:0] load_data,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [KEY_W-1:0] key_out,
    output logic [IW-1:0]    win_idx,
    output logic             win_start,
    output logic             running,
    output logic             keys_ok
);

    localparam logic [IW-1:0] LOAD_LAST = IW'(NKEY - 1);

    knot_state_e      state_q, state_d;
    logic [IW-1:0]    load_idx_q, load_idx_d;
    logic [KEY_W-1:0] key_q [NKEY];
    logic [KEY_W-1:0] key_d [NKEY];
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             running_q, running_d;
    logic             keys_ok_q, keys_ok_d;
    logic             load_acc;
    logic             run_nxt;
    logic [IW-1:0]    win_idx_nxt;

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign load_acc   = load_valid && load_ready;

    // Priority: clear > stop > start > load; each command only acts in its own state.
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        key_d      = key_q;
        if (clear) begin
            state_d    = ST_IDLE;
            load_idx_d = '0;
            for (int i = 0; i < NKEY; i++) key_d[i] = '0;
        end else if (state_q == ST_RUN && stop) begin
            state_d = ST_ARMED;
        end else if (state_q == ST_ARMED && start) begin
            state_d = ST_RUN;
        end else if (load_acc) begin
            key_d[load_idx_q] = load_data;
            if (load_idx_q == LOAD_LAST) begin
                state_d    = ST_ARMED;
                load_idx_d = '0;
            end else begin
                state_d    = ST_LOAD;
                load_idx_d = load_idx_q + 1'b1;
            end
        end
    end

    assign run_nxt = (state_d == ST_RUN);

    always_comb begin
        running_d = run_nxt;
        keys_ok_d = run_nxt || (state_d == ST_ARMED);
        key_out_d = run_nxt ? key_q[win_idx_nxt] : '0;
    end

    knot_window_counter #(
        .NKEY    (NKEY),
        .WIN_LEN (WIN_LEN)
    ) u_win_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          ((state_q == ST_RUN) && run_nxt),
        .clr         (!run_nxt),
        .win_idx     (win_idx),
        .win_idx_nxt (win_idx_nxt),
        .win_start   (win_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            load_idx_q <= '0;
            for (int i = 0; i < NKEY; i++) key_q[i] <= '0;
            key_out_q  <= '0;
            running_q  <= 1'b0;
            keys_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            key_q      <= key_d;
            key_out_q  <= key_out_d;
            running_q  <= running_d;
            keys_ok_q  <= keys_ok_d;
        end
    end

    assign key_out = key_out_q;
    assign running = running_q;
    assign keys_ok = keys_ok_q;

endmodule

// File: tb/tb_knot_key_sequencer.sv
// Directed table-driven bench for knot_key_sequencer with default parameters.
module tb_knot_key_sequencer;
    import knot_lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [6:0] load_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] key_out;
    logic [0:0] win_idx;
    logic       win_start;
    logic       running;
    logic       keys_ok;

    always #5 clk = ~clk;

    knot_key_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .key_out    (key_out),
        .win_idx    (win_idx),
        .win_start  (win_start),
        .running    (running),
        .keys_ok    (keys_ok)
    );

    typedef struct {
        string      name;
        bit         lv;
        logic [6:0] d;
        bit         st;
        bit         sp;
        bit         cl;
        logic [6:0] ek;
        bit         erun;
        bit         ews;
        bit         eok;
        bit         erdy;
        bit         ewi;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void add(string nm, bit lv, logic [6:0] d, bit st, bit sp, bit cl,
                                logic [6:0] ek, bit erun, bit ews, bit eok, bit erdy, bit ewi);
        vec_t v;
        v.name = nm; v.lv = lv; v.d = d; v.st = st; v.sp = sp; v.cl = cl;
        v.ek = ek; v.erun = erun; v.ews = ews; v.eok = eok; v.erdy = erdy; v.ewi = ewi;
        tbl.push_back(v);
    endfunction

    // RUN cycle c (c=0 is the first RUN cycle): window = (c/7)%2, pulse when c%7==0.
    function automatic void add_run(string nm, int c, logic [6:0] k0, logic [6:0] k1,
                                    bit lv, logic [6:0] d);
        bit w;
        w = ((c / 7) % 2) == 1;
        add(nm, lv, d, 1'b0, 1'b0, 1'b0, w ? k1 : k0, 1'b1, (c % 7) == 0, 1'b1, 1'b0, w);
    endfunction

    task automatic check(string nm, logic [6:0] ek, bit erun, bit ews, bit eok, bit erdy, bit ewi);
        n_chk++;
        if (key_out === ek && running === erun && win_start === ews && keys_ok === eok &&
            load_ready === erdy && win_idx === ewi) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got key=%0d run=%b ws=%b ok=%b rdy=%b wi=%0d, expected key=%0d run=%b ws=%b ok=%b rdy=%b wi=%0d",
                     nm, key_out, running, win_start, keys_ok, load_ready, win_idx,
                     ek, erun, ews, eok, erdy, ewi);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            load_valid = tbl[i].lv;
            load_data  = tbl[i].d;
            start      = tbl[i].st;
            stop       = tbl[i].sp;
            clear      = tbl[i].cl;
            @(posedge clk);
            #1;
            check(tbl[i].name, tbl[i].ek, tbl[i].erun, tbl[i].ews, tbl[i].eok, tbl[i].erdy, tbl[i].ewi);
        end
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check("reset", 7'd0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load 66/11, start, watch three windows.
        add("ld0",   1, KNOT2_KEY0, 0, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("ld1",   1, KNOT2_KEY1, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
        add("start", 0, 7'd0,       1, 0, 0, KNOT2_KEY0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 20; c++) add_run("run", c, KNOT2_KEY0, KNOT2_KEY1, 0, 7'd0);

        // Loads offered while ARMED/RUN are refused and never disturb the keys.
        add("stop", 0, 7'd0, 0, 1, 0, 7'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) add("armed_lv", 1, 7'd127, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
        add("start_lv", 1, 7'd127, 1, 0, 0, KNOT2_KEY0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 10; c++) add_run("run_lv", c, KNOT2_KEY0, KNOT2_KEY1, 1, 7'd127);

        // Stop in window 1, restart from phase 0; then stop beats start.
        add("stop_c10", 0, 7'd0, 0, 1, 0, 7'd0, 0, 0, 1, 0, 0);
        add("restart",  0, 7'd0, 1, 0, 0, KNOT2_KEY0, 1, 1, 1, 0, 0);
        add_run("restart_run", 1, KNOT2_KEY0, KNOT2_KEY1, 0, 7'd0);
        add("stop_start", 0, 7'd0, 1, 1, 0, 7'd0, 0, 0, 1, 0, 0);

        // Clear beats start; clear also drops a same-cycle load handshake.
        add("clear_start", 0, 7'd0, 1, 0, 1, 7'd0, 0, 0, 0, 1, 0);
        add("clear_ld",    1, 7'd5, 0, 0, 1, 7'd0, 0, 0, 0, 1, 0);
        add("reld0",       1, 7'd1, 0, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("reld1",       1, 7'd2, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
        add("start12",     0, 7'd0, 1, 0, 0, 7'd1, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 14; c++) add_run("run12", c, 7'd1, 7'd2, 0, 7'd0);

        // Start ignored in IDLE and with only one word loaded.
        add("clear",      0, 7'd0,       0, 0, 1, 7'd0, 0, 0, 0, 1, 0);
        add("start_idle", 0, 7'd0,       1, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("ld0b",       1, KNOT2_KEY0, 0, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("start_one",  0, 7'd0,       1, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("ld1b",       1, KNOT2_KEY1, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
        add("startb",     0, 7'd0,       1, 0, 0, KNOT2_KEY0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 3; c++) add_run("runb", c, KNOT2_KEY0, KNOT2_KEY1, 0, 7'd0);
        run_tbl();

        // Asynchronous reset between edges, mid-window.
        #2 rst_n = 1'b0;
        #1 check("async_rst", 7'd0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst", 7'd0, 0, 0, 0, 1, 0);

        add("ld0c",   1, KNOT2_KEY0, 0, 0, 0, 7'd0, 0, 0, 0, 1, 0);
        add("ld1c",   1, KNOT2_KEY1, 0, 0, 0, 7'd0, 0, 0, 1, 0, 0);
        add("startc", 0, 7'd0,       1, 0, 0, KNOT2_KEY0, 1, 1, 1, 0, 0);
        for (int c = 1; c <= 8; c++) add_run("runc", c, KNOT2_KEY0, KNOT2_KEY1, 0, 7'd0);
        add("clear_run", 0, 7'd0, 0, 0, 1, 7'd0, 0, 0, 0, 1, 0);
        run_tbl();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
